// File: rtl/ctrl_seq.sv
// Registered instruction decoder: one instruction per cycle into register-file,
// ALU, data-memory and fetch controls, with a load/store wait state and a halt state.
module ctrl_seq #(
    parameter int IW     = 9,
    parameter int RW     = 3,
    parameter int MEM_TO = 8
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          instr_valid,
    input  logic [IW-1:0] instr,
    input  logic          zero_in,
    input  logic          mem_ready,
    output logic [RW-1:0] rAddrA,
    output logic [RW-1:0] rAddrB,
    output logic [RW-1:0] wAddr,
    output logic          write_en,
    output logic          ReadMem,
    output logic          WriteMem,
    output logic [2:0]    alu_op,
    output logic          jump_en,
    output logic          branch_en,
    output logic          flag_z,
    output logic          stall,
    output logic          halt,
    output logic          mem_err,
    output logic [1:0]    dbg_state
);

    // Handshake: an instruction is taken on a rising edge where instr_valid=1
    // and the sequencer is in RUN (stall=0); while stall=1 instr must be held
    // and instr_valid is ignored. mem_ready is sampled only while in MEM.
    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_MEM  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SHIFT = 3'b001;
    localparam logic [2:0] OP_STORE = 3'b010;
    localparam logic [2:0] OP_LOAD  = 3'b011;
    localparam logic [2:0] OP_MOVE  = 3'b100;
    localparam logic [2:0] OP_CMP   = 3'b101;
    localparam logic [2:0] OP_JUMP  = 3'b110;
    localparam logic [2:0] OP_BEQ   = 3'b111;

    localparam int CW = $clog2(MEM_TO + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TO - 1);

    state_t        r_state, w_state;
    logic [CW-1:0] r_cnt, w_cnt;
    logic [RW-1:0] r_a, w_a, r_b, w_b, r_w, w_w;
    logic          r_we, w_we, r_rd, w_rd, r_wr, w_wr;
    logic [2:0]    r_alu, w_alu;
    logic          r_jump, w_jump, r_branch, w_branch;
    logic          r_flag, w_flag, r_cmp_pend, w_cmp_pend;
    logic          r_stall, w_stall, r_halt, w_halt, r_err, w_err;

    logic [2:0]    w_opc;
    logic [IW-4:0] w_f;
    logic [RW-1:0] w_ra, w_rb;
    logic          w_bz;

    assign w_opc = instr[IW-1:IW-3];
    assign w_f   = instr[IW-4:0];
    assign w_ra  = w_f[2*RW-1:RW];
    assign w_rb  = w_f[RW-1:0];
    // A CMP issued last cycle has not reached r_flag yet; take the live ALU result.
    assign w_bz  = r_cmp_pend ? zero_in : r_flag;

    always_comb begin
        w_state    = r_state;
        w_cnt      = r_cnt;
        w_a        = r_a;
        w_b        = r_b;
        w_w        = r_w;
        w_we       = 1'b0;
        w_rd       = 1'b0;
        w_wr       = 1'b0;
        w_alu      = r_alu;
        w_jump     = 1'b0;
        w_branch   = 1'b0;
        w_flag     = r_cmp_pend ? zero_in : r_flag;
        w_cmp_pend = 1'b0;
        w_stall    = 1'b0;
        w_halt     = 1'b0;
        w_err      = 1'b0;
        case (r_state)
            S_RUN: begin
                if (instr_valid) begin
                    w_alu = w_opc;
                    case (w_opc)
                        OP_ADD, OP_SHIFT, OP_MOVE: begin
                            w_a  = w_ra;
                            w_b  = w_rb;
                            w_w  = w_ra;
                            w_we = 1'b1;
                        end
                        OP_CMP: begin
                            w_a        = w_ra;
                            w_b        = w_rb;
                            w_cmp_pend = 1'b1;
                        end
                        OP_JUMP: begin
                            w_b    = w_rb;
                            w_jump = 1'b1;
                        end
                        OP_BEQ: begin
                            if (&w_f) begin
                                w_state = S_HALT;
                                w_halt  = 1'b1;
                                w_stall = 1'b1;
                            end else begin
                                w_b      = w_rb;
                                w_branch = 1'b1;
                                w_jump   = w_bz;
                            end
                        end
                        OP_LOAD: begin
                            w_b     = w_rb;
                            w_w     = w_ra;
                            w_rd    = 1'b1;
                            w_stall = 1'b1;
                            w_cnt   = '0;
                            w_state = S_MEM;
                        end
                        default: begin  // OP_STORE
                            w_a     = w_ra;
                            w_b     = w_rb;
                            w_wr    = 1'b1;
                            w_stall = 1'b1;
                            w_cnt   = '0;
                            w_state = S_MEM;
                        end
                    endcase
                end
            end
            S_MEM: begin
                // mem_ready has priority over the timeout on the same cycle.
                if (mem_ready) begin
                    w_state = S_RUN;
                    w_we    = r_rd;
                    w_cnt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state = S_RUN;
                    w_err   = 1'b1;
                    w_cnt   = '0;
                end else begin
                    w_rd    = r_rd;
                    w_wr    = r_wr;
                    w_stall = 1'b1;
                    w_cnt   = r_cnt + CW'(1);
                end
            end
            S_HALT: begin
                w_halt  = 1'b1;
                w_stall = 1'b1;
            end
            default: w_state = S_RUN;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state    <= S_RUN;
            r_cnt      <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_w        <= '0;
            r_we       <= 1'b0;
            r_rd       <= 1'b0;
            r_wr       <= 1'b0;
            r_alu      <= '0;
            r_jump     <= 1'b0;
            r_branch   <= 1'b0;
            r_flag     <= 1'b0;
            r_cmp_pend <= 1'b0;
            r_stall    <= 1'b0;
            r_halt     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_cnt      <= w_cnt;
            r_a        <= w_a;
            r_b        <= w_b;
            r_w        <= w_w;
            r_we       <= w_we;
            r_rd       <= w_rd;
            r_wr       <= w_wr;
            r_alu      <= w_alu;
            r_jump     <= w_jump;
            r_branch   <= w_branch;
            r_flag     <= w_flag;
            r_cmp_pend <= w_cmp_pend;
            r_stall    <= w_stall;
            r_halt     <= w_halt;
            r_err      <= w_err;
        end
    end

    assign rAddrA    = r_a;
    assign rAddrB    = r_b;
    assign wAddr     = r_w;
    assign write_en  = r_we;
    assign ReadMem   = r_rd;
    assign WriteMem  = r_wr;
    assign alu_op    = r_alu;
    assign jump_en   = r_jump;
    assign branch_en = r_branch;
    assign flag_z    = r_flag;
    assign stall     = r_stall;
    assign halt      = r_halt;
    assign mem_err   = r_err;
    assign dbg_state = r_state;

endmodule

// File: doc/ctrl_seq.md
Name: ctrl_seq

Overview:
Parametrised, registered successor to the processor's combinational control decoder. It decodes one instruction word per cycle into register-file, ALU, data-memory and fetch-unit controls. It adds three things the combinational decoder lacks: a multi-cycle load/store handshake with timeout, a persistent compare flag for branch resolution, and a HALT state. It sits between instruction ROM and the register file / ALU / data memory / program counter.

Parameters:
IW, 9, instruction width; opcode = instr[IW-1:IW-3], operand field f = instr[IW-4:0]; IW-3 >= 2*RW required.
RW, 3, register address width; rA = f[2*RW-1:RW], rB = f[RW-1:0].
MEM_TO, 8, max cycles waiting for mem_ready before abort (>=1).

Ports:
Clk  in  1  clock, rising edge.
Reset  in  1  asynchronous, active-high reset.
instr_valid  in  1  instr presents a new instruction this cycle.
instr  in  IW  machine code.
zero_in  in  1  ALU result == 0 (combinational, current cycle).
mem_ready  in  1  data memory completed the requested access.
rAddrA  out  RW  register file read port A.
rAddrB  out  RW  register file read port B.
wAddr  out  RW  register file write address.
write_en  out  1  register file write enable.
ReadMem  out  1  data memory read request.
WriteMem  out  1  data memory write request.
alu_op  out  3  equals opcode of issued instruction.
jump_en  out  1  PC loads target (JUMP, or BEQ taken).
branch_en  out  1  BEQ issued (taken or not).
flag_z  out  1  stored compare result.
stall  out  1  upstream must hold instr; instr_valid ignored.
halt  out  1  processor halted.
mem_err  out  1  one-cycle pulse on memory timeout.

Behaviour:
- Reset: every output 0; FSM = RUN; timeout counter 0; flag_z 0. Reset while in MEM aborts the access; no write_en follows.
- All outputs are registered. Controls appear the cycle after acceptance (latency 1). With no accepted instruction, all pulses (write_en, jump_en, branch_en, ReadMem, WriteMem) are 0, and addresses hold their last value.
- Opcodes: 000 ADD, 001 SHIFT, 100 MOVE: rAddrA=rA, rAddrB=rB, wAddr=rA, write_en=1.
- 101 CMP: rAddrA=rA, rAddrB=rB, write_en=0. Cycle after issue, flag_z <= zero_in.
- 110 JUMP: rAddrB=rB (target register), jump_en=1, write_en=0.
- 111 BEQ: rAddrB=rB, branch_en=1. jump_en = flag_z; when the previous issued instruction was CMP, use zero_in (bypass) instead. Exception: f all ones is HALT.
- 011 LOAD: rAddrB=rB (address), wAddr=rA, ReadMem=1. 010 STORE: rAddrA=rA (data), rAddrB=rB (address), WriteMem=1. Both enter MEM.
- FSM states RUN, MEM, HALT.
- RUN: accept when instr_valid.
- RUN -> MEM on LOAD/STORE issue. stall=1 from the issue cycle onward; ReadMem/WriteMem and addresses are held steady while in MEM.
- MEM, mem_ready=1: next cycle ReadMem/WriteMem=0, stall=0, state RUN. For a LOAD, write_en=1 for exactly that one cycle with wAddr=rA.
- MEM, no mem_ready: counter increments each cycle. When the count reaches MEM_TO, next cycle mem_err=1 (one pulse), controls clear, stall=0, RUN, no write.
- mem_ready in the same cycle as the count reaching MEM_TO: mem_ready wins, no mem_err.
- RUN -> HALT on HALT issue. halt=1 and stall=1 forever; only Reset exits.
- flag_z changes only on CMP.

Test Plan:
- ADD r2,r5: instr=9'b000_010_101, valid 1 cycle -> next cycle rAddrA=2, rAddrB=5, wAddr=2, write_en=1, alu_op=0. Following cycle write_en=0.
- LOAD r1,[r3]: 9'b011_001_011, mem_ready high on 3rd MEM cycle -> ReadMem=1 and stall=1 for 3 cycles, then write_en=1 for 1 cycle with wAddr=1, stall=0. instr_valid pulses during stall are ignored.
- CMP r4,r4 (zero_in=1), then BEQ r6 (9'b111_000_110) back-to-back -> branch_en=1, jump_en=1 via bypass. Repeat with an ADD in between and zero_in=0 at the BEQ -> jump_en still 1 from flag_z.
- STORE with mem_ready never asserted, MEM_TO=8 -> WriteMem held 8 cycles, then one-cycle mem_err, state RUN, no write_en.
- Assert Reset in the 2nd MEM cycle of a LOAD, then deassert, then drive mem_ready -> all outputs 0, no write_en, next ADD decodes normally.
- HALT 9'b111_111_111 -> halt=1, stall=1 persist 20 cycles regardless of instr_valid; Reset clears both.
